// File: rtl/ddr3_line_port.sv
// ddr3_line_port: turns one cache line request into DDR3 controller user-interface
// commands, write beats and read-return collection, then pulses completion.
module ddr3_line_port #(
   parameter int unsigned EXT_ADDR_W  = 26,
   parameter int unsigned LINES_W     = 128,
   parameter int unsigned APP_DATA_W  = 128,
   parameter int unsigned APP_ADDR_W  = 28,
   parameter int unsigned BURST_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    init_calib_complete,
   input  logic                    ext_read_rq,
   input  logic                    ext_write_rq,
   input  logic [EXT_ADDR_W-1:0]   ext_address,
   input  logic [LINES_W-1:0]      ext_write_data,
   output logic [LINES_W-1:0]      ext_read_data,
   output logic                    ext_rq_finished,
   output logic                    busy,
   output logic [APP_ADDR_W-1:0]   app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [APP_DATA_W-1:0]   app_wdf_data,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   output logic [APP_DATA_W/8-1:0] app_wdf_mask,
   input  logic                    app_wdf_rdy,
   input  logic [APP_DATA_W-1:0]   app_rd_data,
   input  logic                    app_rd_data_valid
);

   localparam int unsigned BEATS     = LINES_W / APP_DATA_W;
   localparam int unsigned BEAT_BITS = $clog2(BEATS);
   localparam int unsigned IDX_W     = (BEAT_BITS == 0) ? 1 : BEAT_BITS;
   localparam int unsigned CNT_W     = BEAT_BITS + 1;
   localparam int unsigned FULL_W    = EXT_ADDR_W + BEAT_BITS + BURST_SHIFT;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(BEATS);
   // Forces the beat index to zero when a line is a single beat
   localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(BEATS - 1);

   typedef enum logic [2:0] {StIdle, StRdCmd, StRdWait, StWr, StDone} state_e;

   state_e                  state_q, state_d;
   logic                    armed_q;
   logic [EXT_ADDR_W-1:0]   addr_q;
   logic [LINES_W-1:0]      wr_line_q;
   logic [LINES_W-1:0]      rd_line_q;
   logic [LINES_W-1:0]      rd_out_q;
   logic [LINES_W-1:0]      line_merge;
   logic [CNT_W-1:0]        cmd_cnt_q, cmd_cnt_d;
   logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0]        cmd_idx, wr_idx, rd_idx;
   logic [FULL_W-1:0]       full_addr;
   logic                    accept, cmd_go, wd_go, rd_go;

   // armed_q keeps busy high for the first cycle out of reset
   assign accept = (state_q == StIdle) && init_calib_complete && armed_q;
   assign busy   = ~accept;
   assign cmd_go = app_en && app_rdy;
   assign wd_go  = app_wdf_wren && app_wdf_rdy;
   assign rd_go  = app_rd_data_valid && (rd_cnt_q != LAST) &&
                   ((state_q == StRdCmd) || (state_q == StRdWait));

   assign ext_read_data = rd_out_q;
   assign app_wdf_end   = app_wdf_wren;
   assign app_wdf_mask  = '0;

   // Beat counters: cleared in idle, advanced by their own handshakes
   always_comb begin
      cmd_cnt_d = cmd_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      if (state_q == StIdle) begin
         cmd_cnt_d = '0;
         rd_cnt_d  = '0;
         wr_cnt_d  = '0;
      end else begin
         if (cmd_go) cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
         if (rd_go)  rd_cnt_d  = rd_cnt_q + CNT_W'(1);
         if (wd_go)  wr_cnt_d  = wr_cnt_q + CNT_W'(1);
      end
   end

   // Address, write slice and read merge for the current beats
   always_comb begin
      cmd_idx   = cmd_cnt_q[IDX_W-1:0] & IDX_MASK;
      wr_idx    = wr_cnt_q[IDX_W-1:0] & IDX_MASK;
      rd_idx    = rd_cnt_q[IDX_W-1:0] & IDX_MASK;
      full_addr = (FULL_W'(addr_q) << (BEAT_BITS + BURST_SHIFT)) |
                  (FULL_W'(cmd_idx) << BURST_SHIFT);
      app_addr  = app_en ? APP_ADDR_W'(full_addr) : '0;
      app_wdf_data = app_wdf_wren ? wr_line_q[wr_idx*APP_DATA_W +: APP_DATA_W] : '0;
      line_merge = rd_line_q;
      line_merge[rd_idx*APP_DATA_W +: APP_DATA_W] = app_rd_data;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; write wins when both requests are raised
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && ext_write_rq)     state_d = StWr;
            else if (accept && ext_read_rq) state_d = StRdCmd;
         end
         StRdCmd: begin
            if (rd_cnt_d == LAST)       state_d = StDone;
            else if (cmd_cnt_d == LAST) state_d = StRdWait;
         end
         StRdWait: if (rd_cnt_d == LAST) state_d = StDone;
         StWr:     if ((cmd_cnt_d == LAST) && (wr_cnt_d == LAST)) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output decode; strobes drop as soon as their counter reaches BEATS
   always_comb begin
      app_en          = 1'b0;
      app_cmd         = 3'b000;
      app_wdf_wren    = 1'b0;
      ext_rq_finished = 1'b0;
      unique case (state_q)
         StRdCmd: begin
            app_en  = (cmd_cnt_q != LAST);
            app_cmd = 3'b001;
         end
         StWr: begin
            app_en       = (cmd_cnt_q != LAST);
            app_wdf_wren = (wr_cnt_q != LAST);
         end
         StDone:  ext_rq_finished = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers: request capture, counters and read-line assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q   <= 1'b0;
         addr_q    <= '0;
         wr_line_q <= '0;
         rd_line_q <= '0;
         rd_out_q  <= '0;
         cmd_cnt_q <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         armed_q   <= 1'b1;
         cmd_cnt_q <= cmd_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         if ((state_q == StIdle) && (state_d != StIdle)) begin
            addr_q    <= ext_address;
            wr_line_q <= ext_write_data;
         end
         if (rd_go) begin
            rd_line_q <= line_merge;
            // Output only changes once the whole line has arrived
            if (rd_cnt_d == LAST) rd_out_q <= line_merge;
         end
      end
   end

endmodule

// File: tb/tb_ddr3_line_port.sv
// Scoreboard bench: dut1 has one beat per line, dut2 two 64-bit beats per line.
module tb_ddr3_line_port;

   typedef struct packed {logic [1:0] d; logic [2:0] cmd; logic [27:0] addr;} cmd_t;
   typedef struct packed {logic [1:0] d; logic [127:0] data;} dat_t;

   logic clk = 1'b0;
   logic rst_n, calib;
   // dut1 (BEATS=1)
   logic rd1, wr1, fin1, busy1, app_en1, app_rdy1, wren1, wend1, wrdy1, rd_valid1;
   logic [25:0] addr1;
   logic [127:0] wdata1, rdata1, app_wdf_data1, rd_data1;
   logic [27:0] app_addr1;
   logic [2:0] app_cmd1;
   logic [15:0] mask1;
   // dut2 (BEATS=2)
   logic rd2, wr2, fin2, busy2, app_en2, app_rdy2, wren2, wend2, wrdy2, rd_valid2;
   logic [25:0] addr2;
   logic [127:0] wdata2, rdata2;
   logic [63:0] app_wdf_data2, rd_data2;
   logic [27:0] app_addr2;
   logic [2:0] app_cmd2;
   logic [7:0] mask2;

   int checks = 0;
   int errors = 0;
   cmd_t exp_cmd[$];
   dat_t exp_wd[$];
   dat_t exp_fin[$];
   logic [127:0] last_rd [2];

   always #5 clk = ~clk;

   ddr3_line_port #(.APP_DATA_W(128)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .init_calib_complete(calib),
      .ext_read_rq(rd1), .ext_write_rq(wr1), .ext_address(addr1),
      .ext_write_data(wdata1), .ext_read_data(rdata1), .ext_rq_finished(fin1),
      .busy(busy1), .app_addr(app_addr1), .app_cmd(app_cmd1), .app_en(app_en1),
      .app_rdy(app_rdy1), .app_wdf_data(app_wdf_data1), .app_wdf_wren(wren1),
      .app_wdf_end(wend1), .app_wdf_mask(mask1), .app_wdf_rdy(wrdy1),
      .app_rd_data(rd_data1), .app_rd_data_valid(rd_valid1)
   );

   ddr3_line_port #(.APP_DATA_W(64)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .init_calib_complete(calib),
      .ext_read_rq(rd2), .ext_write_rq(wr2), .ext_address(addr2),
      .ext_write_data(wdata2), .ext_read_data(rdata2), .ext_rq_finished(fin2),
      .busy(busy2), .app_addr(app_addr2), .app_cmd(app_cmd2), .app_en(app_en2),
      .app_rdy(app_rdy2), .app_wdf_data(app_wdf_data2), .app_wdf_wren(wren2),
      .app_wdf_end(wend2), .app_wdf_mask(mask2), .app_wdf_rdy(wrdy2),
      .app_rd_data(rd_data2), .app_rd_data_valid(rd_valid2)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Every strobe seen must match the head of its expected queue
   task automatic mon(input logic [1:0] d, input logic en, input logic rdy,
                      input logic [2:0] cmd, input logic [27:0] addr, input logic wren,
                      input logic wrdy, input logic wend, input logic [127:0] wdat,
                      input logic fin, input logic [127:0] rdat);
      if (en) begin
         chk("cmd_expected", 160'(exp_cmd.size() != 0), 160'(1));
         if (exp_cmd.size() != 0) begin
            chk("cmd", 160'({d, cmd, addr}), 160'(exp_cmd[0]));
            if (rdy) void'(exp_cmd.pop_front());
         end
      end
      if (wren) begin
         chk("wdf_end", 160'(wend), 160'(1));
         chk("wd_expected", 160'(exp_wd.size() != 0), 160'(1));
         if (exp_wd.size() != 0) begin
            chk("wd", 160'({d, wdat}), 160'(exp_wd[0]));
            if (wrdy) void'(exp_wd.pop_front());
         end
      end
      if (fin) begin
         chk("fin_expected", 160'(exp_fin.size() != 0), 160'(1));
         if (exp_fin.size() != 0) chk("rdata", 160'({d, rdat}), 160'(exp_fin.pop_front()));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(2'd0, app_en1, app_rdy1, app_cmd1, app_addr1, wren1, wrdy1, wend1,
             app_wdf_data1, fin1, rdata1);
         mon(2'd1, app_en2, app_rdy2, app_cmd2, app_addr2, wren2, wrdy2, wend2,
             128'(app_wdf_data2), fin2, rdata2);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise a request, hold it until accepted, then scramble the inputs
   task automatic req(input int d, input logic r, input logic w, input logic [25:0] a,
                      input logic [127:0] data);
      int n = 0;
      if (d == 0) begin rd1 = r; wr1 = w; addr1 = a; wdata1 = data; end
      else        begin rd2 = r; wr2 = w; addr2 = a; wdata2 = data; end
      @(negedge clk);
      while (((d == 0) ? busy1 : busy2) && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("accept_in_time", 160'(n < 50), 160'(1));
      @(posedge clk);
      #1;
      if (d == 0) begin rd1 = 0; wr1 = 0; addr1 = '1; wdata1 = '1; end
      else        begin rd2 = 0; wr2 = 0; addr2 = '1; wdata2 = '1; end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_cmd.size() + exp_wd.size() + exp_fin.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 160'(exp_cmd.size() + exp_wd.size() + exp_fin.size()), 160'(0));
      step(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] a5, d5, w2, w4;
      logic [63:0] lo, hi;
      a5 = {16{8'hA5}};
      d5 = {16{8'h5A}};
      w2 = {64'hDEAD_BEEF_0000_0002, 64'h0123_4567_89AB_CDEF};
      w4 = {64'hFEED_FACE_0000_0004, 64'h0000_1111_2222_3333};
      lo = 64'h0011_2233_4455_6677;
      hi = 64'h8899_AABB_CCDD_EEFF;
      last_rd[0] = '0;
      last_rd[1] = '0;
      rst_n = 0; calib = 0;
      {rd1, wr1, app_rdy1, wrdy1, rd_valid1} = '0;
      {rd2, wr2, app_rdy2, wrdy2, rd_valid2} = '0;
      addr1 = '0; wdata1 = '0; rd_data1 = '0;
      addr2 = '0; wdata2 = '0; rd_data2 = '0;

      // Reset values
      step(2);
      @(negedge clk);
      chk("rst_busy1", 160'(busy1), 160'(1));
      chk("rst_busy2", 160'(busy2), 160'(1));
      chk("rst_outs1", 160'({app_en1, app_cmd1, app_addr1, wren1, wend1, mask1, fin1}), 160'(0));
      chk("rst_outs2", 160'({app_en2, app_cmd2, app_addr2, wren2, wend2, mask2, fin2}), 160'(0));
      chk("rst_rdata1", 160'(rdata1), 160'(0));
      chk("rst_wdata2", 160'(app_wdf_data2), 160'(0));
      @(posedge clk);
      #1 rst_n = 1; calib = 1;
      step(2);

      // One-beat read of line 0x12345
      app_rdy1 = 1; wrdy1 = 1;
      exp_cmd.push_back({2'd0, 3'b001, 28'h91A28});
      exp_fin.push_back({2'd0, a5});
      last_rd[0] = a5;
      req(0, 1, 0, 26'h12345, '0);
      step(3);
      rd_valid1 = 1; rd_data1 = a5;
      step(1);
      rd_valid1 = 0; rd_data1 = '0;
      drain();

      // Two-beat write of line 0x10 under data and command backpressure
      app_rdy2 = 0; wrdy2 = 0;
      exp_cmd.push_back({2'd1, 3'b000, 28'h100});
      exp_cmd.push_back({2'd1, 3'b000, 28'h108});
      exp_wd.push_back({2'd1, 64'h0, w2[63:0]});
      exp_wd.push_back({2'd1, 64'h0, w2[127:64]});
      exp_fin.push_back({2'd1, last_rd[1]});
      req(1, 0, 1, 26'h10, w2);
      step(2);
      wrdy2 = 1;
      step(3);
      app_rdy2 = 1;
      drain();

      // Two-beat read with beat 0 returning before the second command
      exp_cmd.push_back({2'd1, 3'b001, 28'h200});
      exp_cmd.push_back({2'd1, 3'b001, 28'h208});
      exp_fin.push_back({2'd1, hi, lo});
      last_rd[1] = {hi, lo};
      req(1, 1, 0, 26'h20, '0);
      step(1);
      app_rdy2 = 0; rd_valid2 = 1; rd_data2 = lo;
      step(1);
      rd_valid2 = 0;
      step(2);
      app_rdy2 = 1;
      step(2);
      rd_valid2 = 1; rd_data2 = hi;
      step(1);
      rd_valid2 = 0;
      drain();

      // Read and write together: write wins, read data held
      exp_cmd.push_back({2'd1, 3'b000, 28'h330});
      exp_cmd.push_back({2'd1, 3'b000, 28'h338});
      exp_wd.push_back({2'd1, 64'h0, w4[63:0]});
      exp_wd.push_back({2'd1, 64'h0, w4[127:64]});
      exp_fin.push_back({2'd1, last_rd[1]});
      req(1, 1, 1, 26'h33, w4);
      drain();

      // Calibration low blocks acceptance; accepted on the edge after it rises
      calib = 0; rd1 = 1; addr1 = 26'h7;
      step(4);
      @(negedge clk);
      chk("busy_uncal", 160'(busy1), 160'(1));
      chk("no_cmd_uncal", 160'(app_en1), 160'(0));
      exp_cmd.push_back({2'd0, 3'b001, 28'h38});
      exp_fin.push_back({2'd0, d5});
      last_rd[0] = d5;
      @(posedge clk);
      #1 calib = 1;
      @(negedge clk);
      chk("busy_cal", 160'(busy1), 160'(0));
      @(posedge clk);
      #1 rd1 = 0;
      @(negedge clk);
      chk("accept_next", 160'(app_en1), 160'(1));
      step(2);
      rd_valid1 = 1; rd_data1 = d5;
      step(1);
      rd_valid1 = 0;
      drain();

      // Reset during RD_WAIT, then stray read data
      exp_cmd.push_back({2'd1, 3'b001, 28'h440});
      exp_cmd.push_back({2'd1, 3'b001, 28'h448});
      req(1, 1, 0, 26'h44, '0);
      step(3);
      chk("rdwait_cmds", 160'(exp_cmd.size()), 160'(0));
      rst_n = 0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
      chk("midrst_outs2", 160'({app_en2, app_cmd2, app_addr2, wren2, wend2, fin2, app_wdf_data2}),
          160'(0));
      chk("midrst_busy2", 160'(busy2), 160'(1));
      chk("midrst_rdata2", 160'(rdata2), 160'(last_rd[1]));
      @(posedge clk);
      #1 rst_n = 1;
      step(1);
      rd_valid2 = 1; rd_data2 = '1;
      step(2);
      rd_valid2 = 0;
      step(4);
      chk("stray_rdata2", 160'(rdata2), 160'(last_rd[1]));
      chk("post_rst_rdata1", 160'(rdata1), 160'(last_rd[0]));
      chk("idle_outs2", 160'({app_en2, wren2, fin2, busy2}), 160'(0));
      chk("queues_empty", 160'(exp_cmd.size() + exp_wd.size() + exp_fin.size()), 160'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
